// File: rtl/fec_sequencer_if.sv
// Host/decoder bundle for fec_sequencer: start/ack handshake, decoder controls, PC and strobes.
// instr_count is present only when FEC_SEQ_INSTR_COUNT_EN is defined.
interface fec_sequencer_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic            branch_en;
  logic            mem_read;
  logic            mem_write;
  logic            done;
  logic            zero;
  logic [7:0]      br_offset;
  logic [PC_W-1:0] pc;
  logic            fetch_en;
  logic            commit;
  logic            busy;
  logic            ack;
`ifdef FEC_SEQ_INSTR_COUNT_EN
  logic [15:0]     instr_count;

  modport master (
    output start, branch_en, mem_read, mem_write, done, zero, br_offset,
    input  pc, fetch_en, commit, busy, ack, instr_count
  );
  modport slave (
    input  start, branch_en, mem_read, mem_write, done, zero, br_offset,
    output pc, fetch_en, commit, busy, ack, instr_count
  );
`else
  modport master (
    output start, branch_en, mem_read, mem_write, done, zero, br_offset,
    input  pc, fetch_en, commit, busy, ack
  );
  modport slave (
    input  start, branch_en, mem_read, mem_write, done, zero, br_offset,
    output pc, fetch_en, commit, busy, ack
  );
`endif
endinterface

// File: rtl/fec_sequencer.sv
// Multicycle fetch/execute sequencer for the 9-bit FEC processor: owns PC, fetch enable and commit.
// Optional commit counter output enabled by defining FEC_SEQ_INSTR_COUNT_EN.
module fec_sequencer #(
  parameter int PC_W     = 10,
  parameter int MEM_LAT  = 2,
  parameter int START_PC = 0
) (
  input  logic           clk,
  input  logic           reset,
  fec_sequencer_if.slave bus
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [PC_W-1:0] START = PC_W'(START_PC);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEMW, S_HALT} state_t;

  state_t           r_state, w_state_next;
  logic [PC_W-1:0]  r_pc, w_pc_next, w_pc_step;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic             r_start_armed, w_start_armed_next;
  logic             r_busy, r_ack;
  logic             w_commit, w_fetch_en;

  // bne taken adds the sign-extended offset; everything else steps by one, both modulo 2^PC_W
  assign w_pc_step = (bus.branch_en && !bus.zero) ? r_pc + PC_W'($signed(bus.br_offset))
                                                  : r_pc + PC_W'(1);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_wait_cnt_next    = r_wait_cnt;
    w_start_armed_next = r_start_armed;
    w_commit           = 1'b0;
    w_fetch_en         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_FETCH;
          w_pc_next    = START;
        end
      end
      S_FETCH: begin
        w_fetch_en   = 1'b1;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        if (bus.done) begin
          w_state_next = S_HALT;
        end else if ((bus.mem_read || bus.mem_write) && (MEM_LAT > 0)) begin
          w_state_next    = S_MEMW;
          w_wait_cnt_next = CNT_W'(MEM_LAT - 1);
        end else begin
          w_commit     = 1'b1;
          w_pc_next    = w_pc_step;
          w_state_next = S_FETCH;
        end
      end
      S_MEMW: begin
        if (r_wait_cnt == '0) begin
          w_commit     = 1'b1;
          w_pc_next    = w_pc_step;
          w_state_next = S_FETCH;
        end else begin
          w_wait_cnt_next = r_wait_cnt - CNT_W'(1);
        end
      end
      S_HALT: begin
        // a start level left over from the previous run must drop before it can restart us
        if (bus.start && r_start_armed) begin
          w_state_next       = S_FETCH;
          w_pc_next          = START;
          w_start_armed_next = 1'b0;
        end else if (!bus.start) begin
          w_start_armed_next = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= START;
      r_wait_cnt    <= '0;
      r_start_armed <= 1'b0;
      r_busy        <= 1'b0;
      r_ack         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_start_armed <= w_start_armed_next;
      r_busy        <= w_state_next inside {S_FETCH, S_EXEC, S_MEMW};
      r_ack         <= (w_state_next == S_HALT);
    end
  end

  assign bus.pc       = r_pc;
  assign bus.fetch_en = w_fetch_en;
  // a reset cycle must never let a write through, even if the state still says commit
  assign bus.commit   = w_commit & ~reset;
  assign bus.busy     = r_busy;
  assign bus.ack      = r_ack;

`ifdef FEC_SEQ_INSTR_COUNT_EN
  logic [15:0] r_instr_count;
  logic        w_start_accept;

  assign w_start_accept = ((r_state == S_IDLE) && bus.start) ||
                          ((r_state == S_HALT) && bus.start && r_start_armed);

  always_ff @(posedge clk) begin
    if (reset || w_start_accept) begin
      r_instr_count <= '0;
    end else if (bus.commit && (r_instr_count != 16'hFFFF)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign bus.instr_count = r_instr_count;
`endif
endmodule
